// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: PS/2 keyboard device transmitter; sends 1-3 framed bytes per key event.
module ps2_kbd_tx #(
    parameter int CLK_DIV = 50,
    parameter int GAP_CYC = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       key_ext,
    input  logic       key_release,
    output logic       key_ready,
    output logic       key_done,
    output logic       ps2_clk,
    output logic       ps2_dat
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam int PW = $clog2(2 * CLK_DIV);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV);
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC);

    state_t        state;
    logic [PW-1:0] phase;
    logic [3:0]    bit_idx;
    logic [GW-1:0] gap_cnt;
    logic [1:0]    byte_cnt;
    logic [7:0]    code;
    logic          ext;
    logic          rel;
    logic [7:0]    cur_byte;
    logic [10:0]   frame;
    logic [1:0]    last_byte;
    logic          accept;

    // Pick the byte being sent (E0, F0 or the code) and build its 11-bit frame.
    always_comb begin
        last_byte = {1'b0, ext} + {1'b0, rel};
        cur_byte  = (ext && byte_cnt == 2'd0) ? 8'hE0 :
                    (rel && byte_cnt == {1'b0, ext}) ? 8'hF0 : code;
        frame     = {1'b1, ~^cur_byte, cur_byte, 1'b0};
        accept    = key_valid & key_ready;
    end

    // Event FSM: serialises each frame, then holds the line idle for the gap.
    // The gap's final edge launches the next start bit directly so frames stay
    // exactly GAP_CYC idle cycles apart within one event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= '0;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            byte_cnt  <= '0;
            code      <= '0;
            ext       <= 1'b0;
            rel       <= 1'b0;
            key_ready <= 1'b1;
            key_done  <= 1'b0;
            ps2_clk   <= 1'b1;
            ps2_dat   <= 1'b1;
        end else begin
            key_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SHIFT;
                        code      <= key_code;
                        ext       <= key_ext;
                        rel       <= key_release;
                        phase     <= '0;
                        bit_idx   <= '0;
                        byte_cnt  <= '0;
                        key_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    ps2_dat <= frame[bit_idx];
                    ps2_clk <= phase < PH_HALF;
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        if (bit_idx == 4'd10) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                GAP: begin
                    ps2_clk <= 1'b1;
                    ps2_dat <= 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (byte_cnt == last_byte) begin
                            state     <= IDLE;
                            key_done  <= 1'b1;
                            key_ready <= 1'b1;
                        end else begin
                            state    <= SHIFT;
                            byte_cnt <= byte_cnt + 2'd1;
                            bit_idx  <= '0;
                            phase    <= PW'(1);
                            ps2_dat  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx: directed table-driven bench for the PS/2 keyboard transmitter.
module tb_ps2_kbd_tx;
    localparam int CD  = 4;
    localparam int GAP = 8;
    localparam int EV  = 22 * CD + GAP;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       key_ready;
    logic       key_done;
    logic       ps2_clk;
    logic       ps2_dat;

    int errors = 0;
    int checks = 0;

    logic clk_tr [512];
    logic dat_tr [512];
    logic rdy_tr [512];
    logic done_tr[512];

    typedef struct {
        logic [7:0]  code;
        logic        ext;
        logic        rel;
        bit          tog;
        int          n;
        logic [23:0] bytes;
        logic [2:0]  par;
    } vec_t;

    vec_t vecs[6];

    ps2_kbd_tx #(.CLK_DIV(CD), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_ext(key_ext), .key_release(key_release), .key_ready(key_ready),
        .key_done(key_done), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one event request and wait for the accept edge (offset 0).
    task automatic start(input logic [7:0] code, input logic ext, input logic rel,
                         input bit keep, input string tag);
        chk({tag, " ready_before"}, {31'd0, key_ready}, 32'd1);
        key_code    = code;
        key_ext     = ext;
        key_release = rel;
        key_valid   = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) key_valid = 1'b0;
        clk_tr[0]  = ps2_clk;
        dat_tr[0]  = ps2_dat;
        rdy_tr[0]  = key_ready;
        done_tr[0] = key_done;
    endtask

    // Record outputs #1 after each edge; optionally toggle key_valid before drop_at.
    task automatic capture(input int len, input int drop_at, input bit tog);
        for (int k = 1; k <= len; k++) begin
            @(posedge clk);
            #1;
            clk_tr[k]  = ps2_clk;
            dat_tr[k]  = ps2_dat;
            rdy_tr[k]  = key_ready;
            done_tr[k] = key_done;
            if (tog && k < drop_at) begin
                key_valid = k[0];
                key_code  = 8'hAA;
            end else if (k >= drop_at) begin
                key_valid = 1'b0;
            end
        end
    endtask

    // Check an event whose accept edge is at trace offset t0.
    task automatic check_event(input string tag, input int t0, input int n,
                               input logic [23:0] bytes, input logic [2:0] par);
        int falls = 0;
        int dones = 0;
        int rdys  = 0;
        int high;
        int s;
        int off;
        logic [10:0] fr;
        for (int k = t0 + 1; k <= t0 + n * EV; k++) begin
            if (clk_tr[k-1] && !clk_tr[k]) falls++;
            if (done_tr[k]) dones++;
            if (rdy_tr[k]) rdys++;
        end
        chk({tag, " falling_edges"}, falls, 11 * n);
        chk({tag, " early_done"}, dones, 0);
        chk({tag, " ready_busy"}, rdys, 0);
        chk({tag, " done_pulse"}, {31'd0, done_tr[t0 + n * EV + 1]}, 32'd1);
        chk({tag, " ready_rise"}, {31'd0, rdy_tr[t0 + n * EV + 1]}, 32'd1);
        for (int f = 0; f < n; f++) begin
            s  = t0 + 1 + f * EV;
            fr = {1'b1, par[f], bytes[8*f +: 8], 1'b0};
            chk($sformatf("%s f%0d start", tag, f), {30'd0, clk_tr[s], dat_tr[s]}, 32'b10);
            if (f > 0) begin
                high = 0;
                for (int g = s - GAP; g < s; g++) if (clk_tr[g] && dat_tr[g]) high++;
                chk($sformatf("%s f%0d gap", tag, f), high, GAP);
                chk($sformatf("%s f%0d stop_low", tag, f), {31'd0, clk_tr[s - GAP - 1]}, 32'd0);
            end
            for (int j = 0; j < 11; j++) begin
                off = s + CD + 2 * CD * j;
                chk($sformatf("%s f%0d b%0d edge", tag, f, j), {30'd0, clk_tr[off-1], clk_tr[off]}, 32'b10);
                chk($sformatf("%s f%0d b%0d data", tag, f, j), {31'd0, dat_tr[off]}, {31'd0, fr[j]});
            end
        end
    endtask

    task automatic idle_check(input string tag);
        int good = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (ps2_clk && ps2_dat && key_ready && !key_done) good++;
        end
        chk({tag, " idle_after"}, good, 10);
    endtask

    initial begin
        vecs[0] = '{code: 8'h1C, ext: 1'b0, rel: 1'b0, tog: 1'b0, n: 1, bytes: 24'h00001C, par: 3'b000};
        vecs[1] = '{code: 8'h75, ext: 1'b1, rel: 1'b1, tog: 1'b0, n: 3, bytes: 24'h75F0E0, par: 3'b010};
        vecs[2] = '{code: 8'h00, ext: 1'b0, rel: 1'b0, tog: 1'b1, n: 1, bytes: 24'h000000, par: 3'b001};
        vecs[3] = '{code: 8'h6B, ext: 1'b1, rel: 1'b0, tog: 1'b0, n: 2, bytes: 24'h006BE0, par: 3'b000};
        vecs[4] = '{code: 8'hFF, ext: 1'b0, rel: 1'b1, tog: 1'b0, n: 2, bytes: 24'h00FFF0, par: 3'b011};
        vecs[5] = '{code: 8'h01, ext: 1'b0, rel: 1'b0, tog: 1'b0, n: 1, bytes: 24'h000001, par: 3'b000};

        rst = 1'b1;
        key_valid = 1'b0;
        key_code = 8'h00;
        key_ext = 1'b0;
        key_release = 1'b0;
        #1;
        chk("reset ps2_clk", {31'd0, ps2_clk}, 32'd1);
        chk("reset ps2_dat", {31'd0, ps2_dat}, 32'd1);
        chk("reset key_ready", {31'd0, key_ready}, 32'd1);
        chk("reset key_done", {31'd0, key_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            start(vecs[v].code, vecs[v].ext, vecs[v].rel, 1'b0, tag);
            capture(vecs[v].n * EV + 1, vecs[v].tog ? vecs[v].n * EV : 1, vecs[v].tog);
            check_event(tag, 0, vecs[v].n, vecs[v].bytes, vecs[v].par);
            idle_check(tag);
        end

        start(8'h1C, 1'b0, 1'b0, 1'b1, "b2b");
        key_code = 8'h32;
        capture(2 * EV + 4, EV + 2, 1'b0);
        check_event("b2b first", 0, 1, 24'h00001C, 3'b000);
        chk("b2b ready_one_cycle", {31'd0, rdy_tr[EV + 2]}, 32'd0);
        check_event("b2b second", EV + 2, 1, 24'h000032, 3'b000);
        idle_check("b2b");

        start(8'h1C, 1'b0, 1'b0, 1'b0, "abort");
        capture(1 + 5 * 2 * CD + CD, 1, 1'b0);
        chk("abort pre clk", {31'd0, clk_tr[1 + 5 * 2 * CD + CD]}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("abort async ps2_clk", {31'd0, ps2_clk}, 32'd1);
        chk("abort async ps2_dat", {31'd0, ps2_dat}, 32'd1);
        chk("abort async key_done", {31'd0, key_done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("abort hold key_done", {31'd0, key_done}, 32'd0);
        rst = 1'b0;
        start(8'h12, 1'b0, 1'b0, 1'b0, "after_rst");
        capture(EV + 1, 1, 1'b0);
        check_event("after_rst", 0, 1, 24'h000012, 3'b001);
        idle_check("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
